// File: rtl/disp2depth_top.sv
`default_nettype none
// ============================================================================
//  Module      : disp2depth_top
//  Description : Streaming disparity-to-depth converter, depth = Tx / disp.
//                Input capture, float unpack, 40-stage restoring divider and
//                an integer / binary16 output formatter. Stall-by-enable.
//  Revision    : 1.0  initial release
// ============================================================================
module disp2depth_top #(
  parameter int DISP_W  = 16,
  parameter int DEPTH_W = 16,
  parameter int N_W     = 40
) (
  input  logic               clk,
  input  logic               rstn,          // synchronous, active-high
  input  logic               clken,
  input  logic               depth_format,
  input  logic [31:0]        Tx,
  input  logic [DISP_W-1:0]  disp,
  output logic [DEPTH_W-1:0] depth,
  output logic               valid
);

  // Exponent at which {1,mant} needs no shift to give |Tx|*2^12, and the
  // first exponent whose result no longer fits in N_W bits.
  localparam logic [7:0] EXP_UNITY = 8'd138;
  localparam logic [7:0] EXP_SAT   = 8'(138 + N_W - 23);
  localparam logic [15:0] INT_MAX  = 16'hFFFF;
  localparam logic [15:0] HALF_INF = 16'h7C00;

  // The sign of Tx is irrelevant: depth is built from |Tx|.
  logic unused_tx_sign;
  assign unused_tx_sign = Tx[31];

  // Input capture: the sample with its own Tx and format.
  logic [30:0]       tx_in;
  logic [DISP_W-1:0] disp_in;
  logic              fmt_in;
  logic              v_in;

  // Unpack result and divider pipeline. Index 0 is the unpack stage output;
  // index s+1 holds the state after quotient bit s has been resolved.
  logic [N_W-1:0]    n0;
  logic [N_W-1:0]    nq   [0:N_W];  // numerator bits shift out, quotient bits shift in
  logic [DISP_W-1:0] rem  [0:N_W-1];
  logic [DISP_W-1:0] dsp  [0:N_W-1];
  logic [N_W:0]      dz;
  logic [N_W:0]      fmt;
  logic [N_W:0]      vld;

  logic [DISP_W:0]   trial [0:N_W-1];
  logic [N_W-1:0]    fits;

  // Format stage signals
  logic [N_W-1:0]    q;
  logic [23:0]       q_lo;
  logic [4:0]        msb;
  logic [9:0]        mant;
  logic [15:0]       int_val;
  logic [15:0]       fp_val;

  logic [7:0]        tx_exp;
  logic [23:0]       tx_man;
  assign tx_exp = tx_in[30:23];
  assign tx_man = {1'b1, tx_in[22:0]};

  // Unpack: N = floor(|Tx| * 2^12), saturated to all ones.
  always_comb begin
    n0 = '0;
    if (tx_exp == 8'd0) begin
      n0 = '0;
    end else if (tx_exp == 8'hFF || tx_exp >= EXP_SAT) begin
      n0 = '1;
    end else if (tx_exp >= EXP_UNITY) begin
      n0 = {{(N_W-24){1'b0}}, tx_man} << (tx_exp - EXP_UNITY);
    end else begin
      n0 = {{(N_W-24){1'b0}}, tx_man} >> (EXP_UNITY - tx_exp);
    end
  end

  // Capture the incoming sample and register the unpacked numerator.
  always_ff @(posedge clk) begin
    if (rstn) begin
      tx_in   <= '0;
      disp_in <= '0;
      fmt_in  <= 1'b0;
      v_in    <= 1'b0;
      nq[0]   <= '0;
      rem[0]  <= '0;
      dsp[0]  <= '0;
      dz[0]   <= 1'b0;
      fmt[0]  <= 1'b0;
      vld[0]  <= 1'b0;
    end else if (clken) begin
      tx_in   <= Tx[30:0];
      disp_in <= disp;
      fmt_in  <= depth_format;
      v_in    <= 1'b1;
      nq[0]   <= n0;
      rem[0]  <= '0;
      dsp[0]  <= disp_in;
      dz[0]   <= (disp_in == '0);
      fmt[0]  <= fmt_in;
      vld[0]  <= v_in;
    end
  end

  // Restoring-divide trial: bring down the next numerator bit and compare.
  always_comb begin
    for (int s = 0; s < N_W; s++) begin
      trial[s] = {rem[s], nq[s][N_W-1]};
      fits[s]  = (trial[s] >= {1'b0, dsp[s]});
    end
  end

  // Divider pipeline: one quotient bit per stage. The last stage keeps no
  // remainder or divisor since nothing downstream needs them.
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int s = 0; s < N_W; s++) begin
        nq[s+1]  <= '0;
        dz[s+1]  <= 1'b0;
        fmt[s+1] <= 1'b0;
        vld[s+1] <= 1'b0;
      end
      for (int s = 0; s < N_W-1; s++) begin
        rem[s+1] <= '0;
        dsp[s+1] <= '0;
      end
    end else if (clken) begin
      for (int s = 0; s < N_W; s++) begin
        nq[s+1]  <= {nq[s][N_W-2:0], fits[s]};
        dz[s+1]  <= dz[s];
        fmt[s+1] <= fmt[s];
        vld[s+1] <= vld[s];
      end
      for (int s = 0; s < N_W-1; s++) begin
        // When the trial fits, trial - dsp < dsp, so the low bits suffice.
        rem[s+1] <= fits[s] ? (trial[s][DISP_W-1:0] - dsp[s]) : trial[s][DISP_W-1:0];
        dsp[s+1] <= dsp[s];
      end
    end
  end

  assign q    = nq[N_W];
  assign q_lo = q[23:0];

  // Format: saturating integer and truncated binary16 from Q (8 frac bits).
  always_comb begin
    msb  = '0;
    mant = '0;
    for (int b = 0; b < 24; b++) begin
      if (q_lo[b]) msb = 5'(b);
    end
    // Mantissa = the ten bits just below the leading one, zero-filled.
    for (int k = 0; k < 10; k++) begin
      int src;
      src = int'(msb) - 10 + k;
      mant[k] = (src >= 0) ? q_lo[src[4:0]] : 1'b0;
    end

    if (dz[N_W] || (|q[N_W-1:24])) int_val = INT_MAX;
    else                           int_val = q[23:8];

    if (dz[N_W])                fp_val = HALF_INF;
    else if (q == '0)           fp_val = 16'h0000;
    else if (|q[N_W-1:24])      fp_val = HALF_INF;
    else                        fp_val = {1'b0, msb + 5'd7, mant};
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rstn) begin
      depth <= '0;
      valid <= 1'b0;
    end else if (clken) begin
      depth <= fmt[N_W] ? fp_val : int_val;
      valid <= vld[N_W];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disp2depth_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp2depth_top
//  Description : Scoreboard bench for disp2depth_top with a real-arithmetic
//                reference model, frame-style enable gaps and mid-frame reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_disp2depth_top;

  localparam int LAT   = 42;
  localparam int ROWS  = 40;
  localparam int COLS  = 718;
  localparam int GAP   = 11;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        clken = 1'b0;
  logic        depth_format = 1'b0;
  logic [31:0] Tx = '0;
  logic [15:0] disp = '0;
  logic [15:0] depth;
  logic        valid;

  disp2depth_top dut (
    .clk          (clk),
    .rstn         (rstn),
    .clken        (clken),
    .depth_format (depth_format),
    .Tx           (Tx),
    .disp         (disp),
    .depth        (depth),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          accepted = 0;
  logic        en_at_edge = 1'b0;
  logic        rst_at_edge = 1'b0;
  logic [15:0] last_depth = '0;
  logic        last_valid = 1'b0;

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: N = floor(|Tx| * 2^12) from the float's value.
  function automatic longint model_n(input logic [31:0] tx);
    int     e;
    real    v;
    longint nmax;
    nmax = (longint'(1) << 40) - 1;
    e = int'(tx[30:23]);
    if (e == 0)   return 0;
    if (e == 255) return nmax;
    v = (8388608.0 + real'(tx[22:0])) * (2.0 ** (e - 150)) * 4096.0;
    if (v >= 1099511627776.0) return nmax;
    return longint'($floor(v));
  endfunction

  function automatic logic [15:0] model_depth(input logic [31:0] tx, input logic [15:0] d,
                                              input logic f);
    longint     n, qv, m;
    int         p;
    logic [4:0] ef;
    logic [9:0] mf;
    if (d == 16'd0) return f ? 16'h7C00 : 16'hFFFF;
    n  = model_n(tx);
    qv = n / longint'(d);
    if (!f) return ((qv >> 8) > 65535) ? 16'hFFFF : 16'(qv >> 8);
    if (qv == 0) return 16'h0000;
    if (qv >= (longint'(1) << 24)) return 16'h7C00;
    p = 0;
    while ((qv >> (p + 1)) != 0) p++;
    m  = ((qv << 10) >> p) - 1024;
    ef = 5'(p + 7);
    mf = m[9:0];
    return {1'b0, ef, mf};
  endfunction

  function automatic logic [31:0] rand_tx();
    int          r;
    logic        s;
    logic [22:0] m;
    r = int'($urandom_range(0, 15));
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom);
    case (r)
      0:       return 32'h0;
      1:       return {s, 8'hFF, m};
      2:       return {s, 8'h00, m};
      3:       return {s, 8'($urandom_range(150, 170)), m};
      default: return {s, 8'($urandom_range(100, 154)), m};
    endcase
  endfunction

  function automatic logic [15:0] rand_disp();
    int r;
    r = int'($urandom_range(0, 15));
    case (r)
      0:       return 16'h0;
      1:       return 16'($urandom_range(1, 16));
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Record what the DUT saw at each active edge.
  always @(posedge clk) begin
    en_at_edge  = clken;
    rst_at_edge = rstn;
  end

  // Monitor: checks reset values, freeze, valid timing and scoreboard order.
  always @(negedge clk) begin
    if (rst_at_edge) begin
      check("reset_depth", depth, 0);
      check("reset_valid", valid, 0);
      accepted = 0;
    end else if (en_at_edge) begin
      accepted++;
      check("valid_timing", valid, (accepted > LAT) ? 1 : 0);
      if (valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("depth", depth, e);
        end
      end
    end else begin
      check("freeze_depth", depth, last_depth);
      check("freeze_valid", valid, last_valid);
    end
    last_depth = depth;
    last_valid = valid;
  end

  task automatic send(input logic [31:0] tx, input logic [15:0] d, input logic f,
                      input logic [15:0] e);
    clken        = 1'b1;
    Tx           = tx;
    disp         = d;
    depth_format = f;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send_model(input logic [31:0] tx, input logic [15:0] d, input logic f);
    send(tx, d, f, model_depth(tx, d, f));
  endtask

  task automatic send_rand();
    logic [31:0] tx;
    logic [15:0] d;
    logic        f;
    tx = rand_tx();
    d  = rand_disp();
    f  = 1'($urandom_range(0, 1));
    send_model(tx, d, f);
  endtask

  task automatic idle(input int n);
    clken = 1'b0;
    repeat (n) begin
      Tx           = $urandom;
      disp         = 16'($urandom);
      depth_format = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn  = 1'b1;
    clken = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    rstn = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;

    // Known-answer samples, with enable gaps in between.
    send(32'h4517FEF4, 16'h0100, 1'b0, 16'd151);
    idle(3);
    send(32'h4517FEF4, 16'h0100, 1'b1, 16'h58BF);
    send(32'h4517FEF4, 16'h0010, 1'b0, 16'd2431);
    send(32'h4517FEF4, 16'h0010, 1'b1, 16'h68BF);
    idle(1);
    send(32'h4517FEF4, 16'h0001, 1'b0, 16'h97FE);
    send(32'h4517FEF4, 16'h0000, 1'b0, 16'hFFFF);
    send(32'h4517FEF4, 16'h0000, 1'b1, 16'h7C00);
    send(32'h3F800000, 16'h0010, 1'b0, 16'd1);
    send(32'h3F800000, 16'h0010, 1'b1, 16'h3C00);
    send(32'h00000000, 16'h0010, 1'b0, 16'h0000);
    send(32'h00000000, 16'h0010, 1'b1, 16'h0000);
    send(32'hC517FEF4, 16'h0100, 1'b0, 16'd151);
    // Boundaries: infinity, saturating exponent, denormal, huge divisor.
    send_model(32'h7F800000, 16'h0001, 1'b0);
    send_model(32'h7F800000, 16'h0001, 1'b1);
    send_model(32'h5F000000, 16'h0010, 1'b1);
    send_model(32'h00400000, 16'h0010, 1'b0);
    send_model(32'h4517FEF4, 16'hFFFF, 1'b1);
    send_model(32'h3F800000, 16'hFFFF, 1'b1);
    idle(GAP);

    // Frame: rows of COLS accepted samples separated by GAP idle cycles,
    // with a reset in the middle of one row.
    for (int row = 0; row < ROWS; row++) begin
      for (int col = 0; col < COLS; col++) begin
        if (row == ROWS / 2 && col == 300) do_reset();
        send_rand();
      end
      idle(GAP);
    end

    // Push enough samples to bring every frame sample out.
    repeat (LAT) send_rand();
    @(negedge clk);
    #1;
    check("in_flight", exp_q.size(), LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
